// File: rtl/lc3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_ctrl_pkg
//  Description : Shared definitions for the LC3 pipeline controller: opcode
//                constants, the memory-access state encoding and opcode
//                classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_ctrl_pkg;

    // Opcodes, IR[15:12]
    localparam logic [3:0] c_OP_BR  = 4'd0;
    localparam logic [3:0] c_OP_ADD = 4'd1;
    localparam logic [3:0] c_OP_LD  = 4'd2;
    localparam logic [3:0] c_OP_ST  = 4'd3;
    localparam logic [3:0] c_OP_AND = 4'd5;
    localparam logic [3:0] c_OP_LDR = 4'd6;
    localparam logic [3:0] c_OP_STR = 4'd7;
    localparam logic [3:0] c_OP_NOT = 4'd9;
    localparam logic [3:0] c_OP_LDI = 4'd10;
    localparam logic [3:0] c_OP_STI = 4'd11;
    localparam logic [3:0] c_OP_JMP = 4'd12;
    localparam logic [3:0] c_OP_LEA = 4'd14;

    // Memory-access phase; the encoding is visible on the mem_state port
    typedef enum logic [1:0] {
        MEM_READ     = 2'd0,
        MEM_INDIRECT = 2'd1,
        MEM_WRITE    = 2'd2,
        MEM_IDLE     = 2'd3
    } mem_state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == c_OP_ADD) || (op == c_OP_AND) || (op == c_OP_NOT);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == c_OP_LD) || (op == c_OP_LDR) || (op == c_OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == c_OP_ST) || (op == c_OP_STR) || (op == c_OP_STI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_fsm
//  Description : Memory-access sequencer. Leaves IDLE when the instruction in
//                Execute is a load/store and steps through INDIRECT, READ or
//                WRITE, advancing on each complete_data pulse.
//  Ports       : clock, reset (async, active-low)
//                start_i         - Execute stage is enabled this cycle
//                opcode_i        - opcode of the instruction in Execute
//                complete_data_i - data-memory access finished
//                mem_state_o     - current access phase
//                mem_stall_o     - an access is in progress
//                load_done_o     - final read of a load completes this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_fsm
    import lc3_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start_i,
    input  logic [3:0] opcode_i,
    input  logic       complete_data_i,
    output mem_state_t mem_state_o,
    output logic       mem_stall_o,
    output logic       load_done_o
);

    mem_state_t state_q;
    // Remembers whether an INDIRECT access belongs to LDI (read next) or STI
    logic       ind_load_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= MEM_IDLE;
            ind_load_q <= 1'b0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (start_i) begin
                        if ((opcode_i == c_OP_LD) || (opcode_i == c_OP_LDR)) begin
                            state_q <= MEM_READ;
                        end else if ((opcode_i == c_OP_ST) || (opcode_i == c_OP_STR)) begin
                            state_q <= MEM_WRITE;
                        end else if ((opcode_i == c_OP_LDI) || (opcode_i == c_OP_STI)) begin
                            state_q    <= MEM_INDIRECT;
                            ind_load_q <= is_load(opcode_i);
                        end
                    end
                end
                MEM_INDIRECT: begin
                    if (complete_data_i) begin
                        state_q <= ind_load_q ? MEM_READ : MEM_WRITE;
                    end
                end
                MEM_READ, MEM_WRITE: begin
                    if (complete_data_i) begin
                        state_q <= MEM_IDLE;
                    end
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    assign mem_state_o = state_q;
    assign mem_stall_o = (state_q != MEM_IDLE);
    assign load_done_o = (state_q == MEM_READ) && complete_data_i;

endmodule
`default_nettype wire

// File: rtl/lc3_pipe_controller.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_pipe_controller
//  Description : Central sequencer of the five-stage LC3 pipeline. Produces
//                stage enables, memory-access state, branch-taken flag and
//                ALU/memory bypass selects. Holds no datapath registers.
//  Ports       : clock, reset (async, active-low)
//                complete_data, complete_instr - memory handshakes
//                IR, IR_Exec, IMem_dout        - Decode / Execute / Fetch words
//                NZP, psr                      - branch condition and flags
//                enable_*                      - per-stage enables
//                br_taken                      - PC loads branch/jump target
//                bypass_{alu,mem}_{1,2}        - Execute operand forwarding
//                mem_state                     - 0 READ 1 INDIRECT 2 WRITE 3 IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_pipe_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int BR_STALL     = 3,
    parameter bit GATE_ON_IMEM = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_data,
    input  logic        complete_instr,
    input  logic [15:0] IR,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] IMem_dout,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic [1:0]  mem_state
);

    localparam int                 c_CNT_W      = (BR_STALL < 2) ? 1 : $clog2(BR_STALL + 1);
    localparam logic [c_CNT_W-1:0] c_STALL_LOAD = c_CNT_W'(BR_STALL);

    logic [3:0]         fill_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               byp_alu_1_q;
    logic               byp_alu_2_q;
    logic               byp_mem_1_q;
    logic               byp_mem_2_q;

    mem_state_t w_mem_state;
    logic       w_mem_stall;
    logic       w_load_done;
    logic [3:0] w_ir_op;
    logic [3:0] w_ex_op;
    logic [3:0] w_if_op;
    logic       w_fetch_ok;
    logic       w_ctrl_trig;
    logic       w_src1_hit;
    logic       w_src2_hit;
    logic       unused_bits;

    assign w_ir_op = IR[15:12];
    assign w_ex_op = IR_Exec[15:12];
    assign w_if_op = IMem_dout[15:12];
    assign unused_bits = ^{IR[4:3], IR_Exec[8:0], IMem_dout[11:0]};

    lc3_mem_fsm u_mem_fsm (
        .clock           (clock),
        .reset           (reset),
        .start_i         (enable_execute),
        .opcode_i        (w_ex_op),
        .complete_data_i (complete_data),
        .mem_state_o     (w_mem_state),
        .mem_stall_o     (w_mem_stall),
        .load_done_o     (w_load_done)
    );

    assign mem_state = w_mem_state;

    // ------------------------------------------------------------------
    // Stage enables. The fill register ramps the stages up one per cycle
    // after reset; a memory access freezes everything upstream of
    // Writeback, and a fetched BR/JMP freezes Fetch until the counter drains.
    // ------------------------------------------------------------------
    assign w_fetch_ok = fill_q[0] & ~w_mem_stall & (cnt_q == '0)
                      & (complete_instr | ~GATE_ON_IMEM);

    assign enable_fetch     = w_fetch_ok;
    assign enable_decode    = fill_q[1] & ~w_mem_stall;
    assign enable_execute   = fill_q[2] & ~w_mem_stall;
    // During an access only the completing read of a load writes back
    assign enable_writeback = w_mem_stall ? w_load_done : fill_q[3];

    // enable_execute is already low during a memory stall, so a branch can
    // never resolve while the pipeline is frozen.
    assign br_taken = enable_execute &
                      (((w_ex_op == c_OP_BR) && ((NZP & psr) != 3'b000)) ||
                       (w_ex_op == c_OP_JMP));

    // The redirect must reach the PC even while Fetch is frozen
    assign enable_updatePC = w_fetch_ok | br_taken;

    assign w_ctrl_trig = w_fetch_ok & ((w_if_op == c_OP_BR) || (w_if_op == c_OP_JMP));

    always_comb begin
        cnt_d = cnt_q;
        if (w_ctrl_trig) begin
            cnt_d = c_STALL_LOAD;
        end else if ((cnt_q != '0) && !w_mem_stall) begin
            cnt_d = cnt_q - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding. src1 is IR[8:6] for ALU/LDR/STR/JMP; src2 is
    // IR[2:0] for register-mode ADD/AND, or the stored register IR[11:9]
    // for stores. Registered at the Decode handoff so they line up with
    // the instruction when it enters Execute.
    // ------------------------------------------------------------------
    assign w_src1_hit = (is_alu(w_ir_op) || (w_ir_op == c_OP_LDR) ||
                         (w_ir_op == c_OP_STR) || (w_ir_op == c_OP_JMP)) &&
                        (IR_Exec[11:9] == IR[8:6]);

    assign w_src2_hit = (((w_ir_op == c_OP_ADD) || (w_ir_op == c_OP_AND)) &&
                         !IR[5] && (IR_Exec[11:9] == IR[2:0])) ||
                        (is_store(w_ir_op) && (IR_Exec[11:9] == IR[11:9]));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_q      <= 4'b0000;
            cnt_q       <= '0;
            byp_alu_1_q <= 1'b0;
            byp_alu_2_q <= 1'b0;
            byp_mem_1_q <= 1'b0;
            byp_mem_2_q <= 1'b0;
        end else begin
            fill_q <= {fill_q[2:0], 1'b1};
            cnt_q  <= cnt_d;
            if (enable_decode) begin
                byp_mem_1_q <= is_load(w_ex_op) & w_src1_hit;
                byp_mem_2_q <= is_load(w_ex_op) & w_src2_hit;
                byp_alu_1_q <= is_alu(w_ex_op) & w_src1_hit & ~is_load(w_ex_op);
                byp_alu_2_q <= is_alu(w_ex_op) & w_src2_hit & ~is_load(w_ex_op);
            end
        end
    end

    assign bypass_alu_1 = byp_alu_1_q;
    assign bypass_alu_2 = byp_alu_2_q;
    assign bypass_mem_1 = byp_mem_1_q;
    assign bypass_mem_2 = byp_mem_2_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_pipe_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lc3_pipe_controller
//  Description : Scoreboard bench for lc3_pipe_controller. The driver applies
//                one input set per cycle and pushes the reference model's
//                expected outputs; the monitor pops and compares each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_pipe_controller;

    localparam int BR_STALL     = 3;
    localparam bit GATE_ON_IMEM = 1'b1;

    localparam logic [15:0] c_ADD_NOP = 16'h1000;

    logic        clock          = 1'b0;
    logic        reset          = 1'b0;
    logic        complete_data  = 1'b0;
    logic        complete_instr = 1'b0;
    logic [15:0] IR             = 16'h0000;
    logic [2:0]  NZP            = 3'b000;
    logic [2:0]  psr            = 3'b000;
    logic [15:0] IR_Exec        = 16'h0000;
    logic [15:0] IMem_dout      = 16'h0000;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute;
    logic        enable_writeback, br_taken;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [1:0]  mem_state;

    always #5 clock = ~clock;

    lc3_pipe_controller #(
        .BR_STALL     (BR_STALL),
        .GATE_ON_IMEM (GATE_ON_IMEM)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .complete_data    (complete_data),
        .complete_instr   (complete_instr),
        .IR               (IR),
        .NZP              (NZP),
        .psr              (psr),
        .IR_Exec          (IR_Exec),
        .IMem_dout        (IMem_dout),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2),
        .mem_state        (mem_state)
    );

    typedef struct packed {
        logic       upc, f, d, e, w, br, a1, a2, m1, m2;
        logic [1:0] mem;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int   age    = 0;   // rising edges seen since reset release (saturating)
    int   steps[$];     // remaining memory phases, front = current phase
    int   freeze = 0;   // cycles fetch remains frozen after a BR/JMP fetch
    bit   m_a1 = 0, m_a2 = 0, m_m1 = 0, m_m2 = 0;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and push the model's expected outputs
    task automatic cyc(input bit r, input bit c_d, input bit c_i,
                       input logic [15:0] i_ir, input logic [15:0] i_irx,
                       input logic [15:0] i_imem,
                       input logic [2:0] i_nzp, input logic [2:0] i_psr);
        exp_t e;
        bit   stall, s1, s2;
        int   xop, dop, fop, dst;
        @(negedge clock);
        reset = r; complete_data = c_d; complete_instr = c_i;
        IR = i_ir; IR_Exec = i_irx; IMem_dout = i_imem; NZP = i_nzp; psr = i_psr;
        #1;
        e = '0;
        if (!r) begin
            e.mem = 2'd3;
            age = 0; steps.delete(); freeze = 0;
            m_a1 = 0; m_a2 = 0; m_m1 = 0; m_m2 = 0;
        end else begin
            stall = (steps.size() != 0);
            xop = int'(i_irx[15:12]);
            dop = int'(i_ir[15:12]);
            fop = int'(i_imem[15:12]);
            e.f   = (age >= 1) && !stall && (freeze == 0) && (c_i || !GATE_ON_IMEM);
            e.d   = (age >= 2) && !stall;
            e.e   = (age >= 3) && !stall;
            e.w   = stall ? ((steps[0] == 0) && c_d) : (age >= 4);
            e.br  = e.e && (((xop == 0) && ((i_nzp & i_psr) != 3'b000)) || (xop == 12));
            e.upc = e.f || e.br;
            e.mem = stall ? 2'(steps[0]) : 2'd3;
            e.a1 = m_a1; e.a2 = m_a2; e.m1 = m_m1; e.m2 = m_m2;
            // advance the model to the next cycle
            if (age < 8) age++;
            if (stall) begin
                if (c_d) void'(steps.pop_front());
            end else if (e.e) begin
                case (xop)
                    2, 6:   steps.push_back(0);
                    3, 7:   steps.push_back(2);
                    10:     begin steps.push_back(1); steps.push_back(0); end
                    11:     begin steps.push_back(1); steps.push_back(2); end
                    default: ;
                endcase
            end
            if (e.f && ((fop == 0) || (fop == 12))) freeze = BR_STALL;
            else if ((freeze > 0) && !stall) freeze--;
            if (e.d) begin
                dst = int'(i_irx[11:9]);
                s1 = (dop inside {1, 5, 9, 6, 7, 12}) && (int'(i_ir[8:6]) == dst);
                s2 = ((dop inside {1, 5}) && !i_ir[5] && (int'(i_ir[2:0]) == dst)) ||
                     ((dop inside {3, 7, 11}) && (int'(i_ir[11:9]) == dst));
                m_a1 = s1 && (xop inside {1, 5, 9});
                m_a2 = s2 && (xop inside {1, 5, 9});
                m_m1 = s1 && (xop inside {2, 6, 10});
                m_m2 = s2 && (xop inside {2, 6, 10});
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: samples mid-cycle, after the driver has pushed its expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("enable_updatePC",  {1'b0, enable_updatePC},  {1'b0, e.upc});
                chk("enable_fetch",     {1'b0, enable_fetch},     {1'b0, e.f});
                chk("enable_decode",    {1'b0, enable_decode},    {1'b0, e.d});
                chk("enable_execute",   {1'b0, enable_execute},   {1'b0, e.e});
                chk("enable_writeback", {1'b0, enable_writeback}, {1'b0, e.w});
                chk("br_taken",         {1'b0, br_taken},         {1'b0, e.br});
                chk("bypass_alu_1",     {1'b0, bypass_alu_1},     {1'b0, e.a1});
                chk("bypass_alu_2",     {1'b0, bypass_alu_2},     {1'b0, e.a2});
                chk("bypass_mem_1",     {1'b0, bypass_mem_1},     {1'b0, e.m1});
                chk("bypass_mem_2",     {1'b0, bypass_mem_2},     {1'b0, e.m2});
                chk("mem_state",        mem_state,                e.mem);
            end
        end
    end

    task automatic nop(input int n);
        for (int k = 0; k < n; k++)
            cyc(1, 0, 1, c_ADD_NOP, c_ADD_NOP, c_ADD_NOP, 3'b000, 3'b000);
    endtask

    initial begin
        // Reset, then pipeline fill with an ADD stream
        repeat (3) cyc(0, 0, 1, c_ADD_NOP, c_ADD_NOP, c_ADD_NOP, 3'b000, 3'b000);
        nop(6);

        // LDI: INDIRECT -> READ -> IDLE, writeback only on the final read
        cyc(1, 0, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 0, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 1, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 0, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 0, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 1, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        nop(2);

        // STR: one WRITE cycle, never a writeback; complete_data in IDLE ignored
        cyc(1, 1, 1, c_ADD_NOP, 16'h7000, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 1, 1, c_ADD_NOP, 16'h7000, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 1, 1, c_ADD_NOP, c_ADD_NOP, c_ADD_NOP, 3'b000, 3'b000);
        nop(1);

        // Fetch BRz, fetch frozen, then taken / not-taken / NZP=000 / JMP
        cyc(1, 0, 1, c_ADD_NOP, c_ADD_NOP, 16'h0400, 3'b000, 3'b000);
        nop(3);
        cyc(1, 0, 1, c_ADD_NOP, 16'h0400, c_ADD_NOP, 3'b010, 3'b010);
        cyc(1, 0, 1, c_ADD_NOP, 16'h0400, c_ADD_NOP, 3'b010, 3'b100);
        cyc(1, 0, 1, c_ADD_NOP, 16'h0000, c_ADD_NOP, 3'b000, 3'b111);
        cyc(1, 0, 1, c_ADD_NOP, 16'hC000, c_ADD_NOP, 3'b000, 3'b000);
        // Fetch gated by complete_instr
        cyc(1, 0, 0, c_ADD_NOP, c_ADD_NOP, c_ADD_NOP, 3'b000, 3'b000);
        nop(1);

        // Bypass: ADD R1 in Execute, ADD R3,R1,R1 in Decode; then LDR R1
        cyc(1, 0, 1, 16'h1641, 16'h1240, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 0, 1, 16'h1641, 16'h6240, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 1, 1, 16'h1641, 16'h6240, c_ADD_NOP, 3'b000, 3'b000);
        nop(2);

        // Reset asserted during an INDIRECT access, then refill
        cyc(1, 0, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        cyc(1, 0, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        cyc(0, 0, 1, c_ADD_NOP, 16'hA200, c_ADD_NOP, 3'b000, 3'b000);
        nop(6);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 299) != 0,
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) < 8,
                16'($urandom), 16'($urandom), 16'($urandom),
                3'($urandom), 3'($urandom));
        end

        @(negedge clock);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
